// File: rtl/ahb_arbiter_if.sv
// ahb_arbiter_if
//   Bundles the arbiter's bus-facing signals.
//   Requests/locks come from the managers. The HTRANS/HBURST/HREADY/HRESP
//   group is the muxed bus as seen by the arbiter. Grant, owner index and
//   lock flag flow back out.
//   modport master : manager/bus side (drives requests and bus status)
//   modport slave  : arbiter side (drives HGRANT, HMASTER, HMASTLOCK)
interface ahb_arbiter_if #(
   parameter int NUM_MASTERS = 4
);
   logic [NUM_MASTERS-1:0] HBUSREQ;
   logic [NUM_MASTERS-1:0] HLOCK;
   logic [1:0]             HTRANS;
   logic [2:0]             HBURST;
   logic                   HREADY;
   logic [1:0]             HRESP;
   logic [NUM_MASTERS-1:0] HGRANT;
   logic [3:0]             HMASTER;
   logic                   HMASTLOCK;

   modport master (
      output HBUSREQ, HLOCK, HTRANS, HBURST, HREADY, HRESP,
      input  HGRANT, HMASTER, HMASTLOCK
   );

   modport slave (
      input  HBUSREQ, HLOCK, HTRANS, HBURST, HREADY, HRESP,
      output HGRANT, HMASTER, HMASTLOCK
   );
endinterface

// File: rtl/ahb_arbiter.sv
// ahb_arbiter
//   Round-robin AHB arbiter for up to 16 managers.
//   Grant handover waits for the end of fixed-length bursts and for the end of
//   locked sequences. Handover is frozen by wait states. When nobody requests,
//   the bus parks on DEFAULT_MASTER.
// Ports
//   HCLK    : bus clock
//   HRESET  : synchronous active-high reset
//   bus     : ahb_arbiter_if.slave
//             requests and locks plus muxed HTRANS/HBURST/HREADY/HRESP in;
//             HGRANT (one-hot), HMASTER and HMASTLOCK out, all registered
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_PARK  | default manager granted because nobody requested
// ST_OWN   | a requester owns the grant, handover allowed on HREADY
// ST_BURST | fixed burst with more than one beat still to issue, hold
// ST_LOCK  | owner asserted HLOCK when granted, hold while HLOCK stays
module ahb_arbiter #(
   parameter int NUM_MASTERS    = 4,
   parameter int DEFAULT_MASTER = 0
) (
   input logic          HCLK,
   input logic          HRESET,
   ahb_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      ST_PARK  = 2'd0,
      ST_OWN   = 2'd1,
      ST_BURST = 2'd2,
      ST_LOCK  = 2'd3
   } state_t;

   localparam logic [1:0] TRANS_NONSEQ = 2'd2;
   localparam logic [1:0] TRANS_SEQ    = 2'd3;
   localparam logic [1:0] RESP_OKAY    = 2'd0;

   localparam logic [3:0] DEF_IDX = 4'(DEFAULT_MASTER);
   localparam logic [NUM_MASTERS-1:0] DEF_GRANT =
      {{(NUM_MASTERS-1){1'b0}}, 1'b1} << DEFAULT_MASTER;

   state_t                 state_q, state_nxt;
   logic [3:0]             gidx_q, gidx_nxt;
   logic [3:0]             last_q, last_nxt;
   logic [4:0]             beat_q, beat_nxt;
   logic [NUM_MASTERS-1:0] grant_q, grant_nxt;
   logic [3:0]             hmaster_q, hmaster_nxt;
   logic                   hmastlock_q, hmastlock_nxt;

   logic [15:0] req_ext;
   logic [15:0] lock_ext;
   logic        resp_abort;
   logic        arb_en;
   logic        rr_found;
   logic [3:0]  rr_idx;

   // Zero-pad to 16 bits so a 4-bit manager index can address either vector
   // whatever NUM_MASTERS is.
   assign req_ext    = 16'(bus.HBUSREQ);
   assign lock_ext   = 16'(bus.HLOCK);
   assign resp_abort = (bus.HRESP != RESP_OKAY);

   // Beats remaining after the accepted one, minus one for the beat in flight.
   function automatic logic [4:0] burst_last_beat(input logic [2:0] hburst);
      logic [4:0] n;
      case (hburst)
         3'd2, 3'd3: n = 5'd3;
         3'd4, 3'd5: n = 5'd7;
         3'd6, 3'd7: n = 5'd15;
         default:    n = 5'd0;
      endcase
      return n;
   endfunction

   function automatic logic [3:0] rr_wrap(input logic [3:0] base, input int ofs);
      int sum;
      sum = int'(base) + ofs;
      if (sum >= NUM_MASTERS) sum = sum - NUM_MASTERS;
      return 4'(sum);
   endfunction

   always_comb begin
      beat_nxt = beat_q;
      if (bus.HREADY) begin
         case (bus.HTRANS)
            TRANS_NONSEQ: beat_nxt = burst_last_beat(bus.HBURST);
            TRANS_SEQ:    beat_nxt = (beat_q == 5'd0) ? 5'd0 : beat_q - 5'd1;
            default:      beat_nxt = beat_q;
         endcase
      end else if (resp_abort) begin
         // First cycle of a two-cycle error/retry/split response: the burst is
         // dead, so release the hold for the following ready edge.
         beat_nxt = 5'd0;
      end
   end

   // The search walks offsets from farthest to nearest. The nearest asserted
   // request after last_grant is therefore the one left standing. The current
   // owner sits at offset NUM_MASTERS and has the lowest priority.
   always_comb begin
      rr_found = 1'b0;
      rr_idx   = last_q;
      for (int ofs = NUM_MASTERS; ofs >= 1; ofs--) begin
         if (req_ext[rr_wrap(last_q, ofs)]) begin
            rr_found = 1'b1;
            rr_idx   = rr_wrap(last_q, ofs);
         end
      end
   end

   always_comb begin
      state_nxt     = state_q;
      gidx_nxt      = gidx_q;
      last_nxt      = last_q;
      hmaster_nxt   = hmaster_q;
      hmastlock_nxt = hmastlock_q;
      arb_en        = 1'b0;

      if (!bus.HREADY) begin
         if (resp_abort && state_q == ST_BURST) state_nxt = ST_OWN;
      end else begin
         hmaster_nxt   = gidx_q;
         hmastlock_nxt = lock_ext[gidx_q];
         if (state_q == ST_LOCK && lock_ext[gidx_q]) begin
            state_nxt = ST_LOCK;
         end else if (beat_nxt > 5'd1) begin
            // This also catches the NONSEQ that opens a burst, so the owner
            // keeps the bus until the last beat's address phase.
            state_nxt = ST_BURST;
         end else begin
            arb_en = 1'b1;
         end
      end

      if (arb_en) begin
         if (rr_found) begin
            gidx_nxt  = rr_idx;
            last_nxt  = rr_idx;
            state_nxt = lock_ext[rr_idx] ? ST_LOCK : ST_OWN;
         end else begin
            gidx_nxt  = DEF_IDX;
            state_nxt = ST_PARK;
         end
      end
   end

   always_comb begin
      grant_nxt = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         grant_nxt[i] = (gidx_nxt == 4'(i));
      end
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_q     <= ST_PARK;
         gidx_q      <= DEF_IDX;
         last_q      <= DEF_IDX;
         beat_q      <= 5'd0;
         grant_q     <= DEF_GRANT;
         hmaster_q   <= DEF_IDX;
         hmastlock_q <= 1'b0;
      end else begin
         state_q     <= state_nxt;
         gidx_q      <= gidx_nxt;
         last_q      <= last_nxt;
         beat_q      <= beat_nxt;
         grant_q     <= grant_nxt;
         hmaster_q   <= hmaster_nxt;
         hmastlock_q <= hmastlock_nxt;
      end
   end

   assign bus.HGRANT    = grant_q;
   assign bus.HMASTER   = hmaster_q;
   assign bus.HMASTLOCK = hmastlock_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
// tb_ahb_arbiter
//   Drives ahb_arbiter with directed sequences and random traffic.
//   A reference model predicts HGRANT/HMASTER/HMASTLOCK after every edge.
//   A separate monitor compares each prediction against the DUT.
module tb_ahb_arbiter;
   localparam int N   = 4;
   localparam int DEF = 0;

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] NONSEQ = 2'd2;
   localparam logic [1:0] SEQ    = 2'd3;
   localparam logic [2:0] SINGLE = 3'd0;
   localparam logic [2:0] INCR4  = 3'd3;
   localparam logic [2:0] INCR8  = 3'd5;

   logic HCLK = 1'b0;
   logic HRESET;

   ahb_arbiter_if #(.NUM_MASTERS(N)) bus ();

   ahb_arbiter #(.NUM_MASTERS(N), .DEFAULT_MASTER(DEF)) dut (
      .HCLK   (HCLK),
      .HRESET (HRESET),
      .bus    (bus)
   );

   always #5 HCLK = ~HCLK;

   typedef struct packed {
      logic [N-1:0] grant;
      logic [3:0]   master;
      logic         mlock;
   } exp_t;

   exp_t sb_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // Reference model: owner, round-robin pointer, beats left, lock tenure.
   int m_owner  = DEF;
   int m_last   = DEF;
   int m_beats  = 0;
   int m_master = DEF;
   bit m_locked = 1'b0;
   bit m_mlock  = 1'b0;

   function automatic int burst_len(input logic [2:0] b);
      if (b == 3'd2 || b == 3'd3) return 4;
      if (b == 3'd4 || b == 3'd5) return 8;
      if (b == 3'd6 || b == 3'd7) return 16;
      return 1;
   endfunction

   task automatic model_edge();
      int nb;
      if (HRESET) begin
         m_owner = DEF; m_last = DEF; m_beats = 0;
         m_master = DEF; m_mlock = 1'b0; m_locked = 1'b0;
         return;
      end
      if (!bus.HREADY) begin
         if (bus.HRESP != 2'd0) m_beats = 0;
         return;
      end
      nb = m_beats;
      if (bus.HTRANS == NONSEQ) nb = burst_len(bus.HBURST) - 1;
      else if (bus.HTRANS == SEQ && nb > 0) nb = nb - 1;
      m_beats  = nb;
      m_master = m_owner;
      m_mlock  = bus.HLOCK[m_owner];
      if (m_locked && bus.HLOCK[m_owner]) return;
      m_locked = 1'b0;
      if (nb > 1) return;
      for (int k = 1; k <= N; k++) begin
         int c;
         c = (m_last + k) % N;
         if (bus.HBUSREQ[c]) begin
            m_owner  = c;
            m_last   = c;
            m_locked = bus.HLOCK[c];
            return;
         end
      end
      m_owner = DEF;
   endtask

   task automatic cyc(input bit rst, input logic [N-1:0] req, input logic [N-1:0] lck,
                      input logic [1:0] trans, input logic [2:0] burst,
                      input bit rdy, input logic [1:0] resp);
      exp_t         e;
      logic [N-1:0] one;
      @(negedge HCLK);
      HRESET      = rst;
      bus.HBUSREQ = req;
      bus.HLOCK   = lck;
      bus.HTRANS  = trans;
      bus.HBURST  = burst;
      bus.HREADY  = rdy;
      bus.HRESP   = resp;
      model_edge();
      one      = 1;
      e.grant  = one << m_owner;
      e.master = 4'(m_master);
      e.mlock  = m_mlock;
      sb_q.push_back(e);
      @(posedge HCLK);
      #2;
   endtask

   task automatic idle(input logic [N-1:0] req, input logic [N-1:0] lck);
      cyc(1'b0, req, lck, IDLE, SINGLE, 1'b1, 2'd0);
   endtask

   task automatic do_reset();
      cyc(1'b1, '0, '0, IDLE, SINGLE, 1'b1, 2'd0);
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Monitor: one prediction per edge, compared just after the edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge HCLK);
         #1;
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            n_tests++;
            if ({bus.HGRANT, bus.HMASTER, bus.HMASTLOCK} !== {e.grant, e.master, e.mlock}) begin
               n_fail++;
               $display("FAIL scoreboard @%0t: got grant=%b master=%0d mlock=%b, expected grant=%b master=%0d mlock=%b",
                        $time, bus.HGRANT, bus.HMASTER, bus.HMASTLOCK, e.grant, e.master, e.mlock);
            end
         end
      end
   end

   initial begin
      logic [3:0]   g_seq [5];
      int           m_seq [5];
      logic [N-1:0] rq, lk;
      logic [1:0]   tr, rs;
      logic [2:0]   bu;
      bit           rd, rt;

      HRESET      = 1'b1;
      bus.HBUSREQ = '0;
      bus.HLOCK   = '0;
      bus.HTRANS  = IDLE;
      bus.HBURST  = SINGLE;
      bus.HREADY  = 1'b1;
      bus.HRESP   = 2'd0;

      // Reset and parking on the default manager.
      do_reset();
      do_reset();
      for (int i = 0; i < 10; i++) begin
         idle('0, '0);
         chk("park_grant", int'(bus.HGRANT), 1);
         chk("park_master", int'(bus.HMASTER), 0);
         chk("park_mlock", int'(bus.HMASTLOCK), 0);
      end

      // Single requester, then release.
      idle(4'b0100, '0);
      chk("req2_grant", int'(bus.HGRANT), 4);
      chk("req2_master_lag", int'(bus.HMASTER), 0);
      idle(4'b0100, '0);
      chk("req2_master", int'(bus.HMASTER), 2);
      idle('0, '0);
      chk("drop_grant", int'(bus.HGRANT), 1);

      // All managers requesting, SINGLE transfers.
      g_seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
      m_seq = '{0, 1, 2, 3, 0};
      do_reset();
      for (int i = 0; i < 5; i++) begin
         cyc(1'b0, 4'b1111, '0, NONSEQ, SINGLE, 1'b1, 2'd0);
         chk("rr_grant", int'(bus.HGRANT), int'(g_seq[i]));
         chk("rr_master", int'(bus.HMASTER), m_seq[i]);
      end

      // INCR4 from manager 1 with manager 3 waiting.
      do_reset();
      idle(4'b0010, '0);
      idle(4'b0010, '0);
      cyc(1'b0, 4'b1010, '0, NONSEQ, INCR4, 1'b1, 2'd0);
      chk("incr4_hold1", int'(bus.HGRANT), 2);
      cyc(1'b0, 4'b1010, '0, SEQ, INCR4, 1'b1, 2'd0);
      chk("incr4_hold2", int'(bus.HGRANT), 2);
      cyc(1'b0, 4'b1010, '0, SEQ, INCR4, 1'b1, 2'd0);
      chk("incr4_handover", int'(bus.HGRANT), 8);
      chk("incr4_master_b3", int'(bus.HMASTER), 1);
      cyc(1'b0, 4'b1000, '0, SEQ, INCR4, 1'b1, 2'd0);
      chk("incr4_master_b4", int'(bus.HMASTER), 3);

      // Same burst with two wait states after beat 2.
      do_reset();
      idle(4'b0010, '0);
      idle(4'b0010, '0);
      cyc(1'b0, 4'b1010, '0, NONSEQ, INCR4, 1'b1, 2'd0);
      cyc(1'b0, 4'b1010, '0, SEQ, INCR4, 1'b1, 2'd0);
      for (int i = 0; i < 2; i++) begin
         cyc(1'b0, 4'b1010, '0, SEQ, INCR4, 1'b0, 2'd0);
         chk("wait_hold_grant", int'(bus.HGRANT), 2);
         chk("wait_hold_master", int'(bus.HMASTER), 1);
      end
      cyc(1'b0, 4'b1010, '0, SEQ, INCR4, 1'b1, 2'd0);
      chk("wait_handover", int'(bus.HGRANT), 8);
      cyc(1'b0, 4'b1000, '0, SEQ, INCR4, 1'b1, 2'd0);
      chk("wait_master_b4", int'(bus.HMASTER), 3);

      // Locked sequence from manager 2 outlives its request.
      do_reset();
      idle(4'b0100, 4'b0100);
      chk("lock_grant0", int'(bus.HGRANT), 4);
      for (int i = 0; i < 3; i++) begin
         idle(4'b1011, 4'b0100);
         chk("lock_hold_grant", int'(bus.HGRANT), 4);
         chk("lock_mlock", int'(bus.HMASTLOCK), 1);
      end
      idle(4'b1011, 4'b0000);
      chk("lock_release", int'(bus.HGRANT), 8);

      // ERROR on beat 2 of an INCR8 ends the hold.
      do_reset();
      idle(4'b0010, '0);
      idle(4'b0010, '0);
      cyc(1'b0, 4'b0110, '0, NONSEQ, INCR8, 1'b1, 2'd0);
      cyc(1'b0, 4'b0110, '0, SEQ, INCR8, 1'b1, 2'd0);
      cyc(1'b0, 4'b0110, '0, SEQ, INCR8, 1'b0, 2'd1);
      chk("err_first_cycle", int'(bus.HGRANT), 2);
      cyc(1'b0, 4'b0110, '0, IDLE, SINGLE, 1'b1, 2'd1);
      chk("err_handover", int'(bus.HGRANT), 4);

      // Reset in the middle of a locked burst, during a wait state.
      do_reset();
      idle(4'b0010, 4'b0010);
      idle(4'b0010, 4'b0010);
      cyc(1'b0, 4'b0010, 4'b0010, NONSEQ, INCR8, 1'b1, 2'd0);
      chk("pre_rst_mlock", int'(bus.HMASTLOCK), 1);
      cyc(1'b1, 4'b1111, 4'b1111, SEQ, INCR8, 1'b0, 2'd0);
      chk("rst_grant", int'(bus.HGRANT), 1);
      chk("rst_master", int'(bus.HMASTER), 0);
      chk("rst_mlock", int'(bus.HMASTLOCK), 0);

      // Random traffic against the model.
      lk = '0;
      for (int c = 0; c < 3000; c++) begin
         rq = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
         if (c % 8 == 0) lk = N'($urandom) & N'($urandom);
         tr = 2'($urandom);
         bu = 3'($urandom);
         rd = ($urandom_range(0, 4) != 0);
         rs = (!rd && $urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
         rt = ($urandom_range(0, 199) == 0);
         cyc(rt, rq, lk, tr, bu, rd, rs);
      end

      idle('0, '0);
      @(negedge HCLK);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ahb_arbiter.md
# ahb_arbiter

Round-robin AHB bus arbiter that shares one AHB address/data bus between up to 16 bus managers. It collects the HBUSREQ/HLOCK pairs from each manager and returns one-hot HGRANT. It drives HMASTER and HMASTLOCK for the slave-side multiplexers and splitter. Grant handover respects fixed-length bursts, locked sequences and HREADY wait states; when nobody requests, the bus parks on a default manager.

## Interface
- NUM_MASTERS, 4, number of managers, legal range 2..16
- DEFAULT_MASTER, 0, manager index granted at reset and when no requests are pending
- HCLK  in  1  bus clock; all state updates on the rising edge
- HRESET  in  1  synchronous, active-high reset
- HBUSREQ  in  NUM_MASTERS  per-manager bus request, bit i = manager i
- HLOCK  in  NUM_MASTERS  per-manager locked-transfer request
- HTRANS  in  2  muxed bus transfer type (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3)
- HBURST  in  3  muxed bus burst type
- HREADY  in  1  muxed bus ready; a transfer is accepted on an edge where HREADY=1
- HRESP  in  2  muxed bus response (OKAY=0, ERROR=1, RETRY=2, SPLIT=3)
- HGRANT  out  NUM_MASTERS  one-hot grant, registered
- HMASTER  out  4  index of the manager owning the current address phase, registered
- HMASTLOCK  out  1  current address phase is locked, registered

## Operation
- Burst length from HBURST: SINGLE=1 and INCR=0 are unbounded/no hold. WRAP4/INCR4 give 4 beats, WRAP8/INCR8 give 8, WRAP16/INCR16 give 16.
- beat_cnt (5 bits) counts the beats still to be issued after the accepted one:
  - NONSEQ accepted with a fixed burst: load beats-1.
  - SEQ accepted: decrement, saturating at 0.
  - NONSEQ with SINGLE/INCR: load 0.
  - IDLE/BUSY: no change.
- beat_cnt_next is the value beat_cnt takes at the current edge.
- FSM states:
  - PARK: default manager granted, no requests.
  - OWN: a requester is granted, no burst hold.
  - BURST: beat_cnt_next > 1.
  - LOCK: the granted manager's HLOCK=1.
- Arbitration happens only on an edge with HREADY=1 and state not BURST/LOCK, or on an edge where BURST reaches beat_cnt_next ≤ 1.
- Handover therefore occurs during the last beat's address phase.
- LOCK holds the grant regardless of other requests or of the owner's HBUSREQ, for as long as HLOCK[owner]=1. It exits to arbitration on the first HREADY=1 edge with HLOCK[owner]=0.
- Round-robin: search starts at last_grant+1 modulo NUM_MASTERS. The first asserted HBUSREQ wins, and last_grant is updated to it.
  - No request pending: grant DEFAULT_MASTER and enter PARK; last_grant is unchanged.
  - The current owner keeps the grant only if it is the round-robin winner.
- HMASTER/HMASTLOCK update on every HREADY=1 edge: HMASTER ← index of the current HGRANT, HMASTLOCK ← HLOCK[that index]. With HREADY=0 both hold.
- HRESP ERROR/RETRY/SPLIT with HREADY=0 (first response cycle): beat_cnt cleared to 0 and BURST exits. Arbitration is permitted at the next HREADY=1 edge. SPLIT masking is not supported.
- HREADY=0 freezes HGRANT, state, last_grant and beat_cnt (except the error clear above).

## Timing
- Reset (HRESET=1 at an edge), applied to all state regardless of HREADY or ongoing burst/lock:
  - HGRANT = one-hot DEFAULT_MASTER
  - HMASTER = DEFAULT_MASTER
  - HMASTLOCK = 0
  - last_grant = DEFAULT_MASTER
  - beat_cnt = 0
  - state PARK
- Request-to-grant latency: 1 edge when arbitration is permitted, HREADY=1 and the requester wins.
- Grant-to-HMASTER latency: the next HREADY=1 edge after the HGRANT change. Wait states stretch this.
- A request that drops before the arbitration edge is never granted; there is no request latching.
- Simultaneous requests from all managers: ownership rotates, each manager owns at most one arbitration slot before every other requester is served.
- Bursts that cross 16 beats or carry an illegal HTRANS sequence are not checked; beat_cnt simply saturates at 0.

## Test plan
- Reset with DEFAULT_MASTER=0 and all HBUSREQ=0, HREADY=1 → HGRANT=0001, HMASTER=0, HMASTLOCK=0, stable for 10 cycles.
- HBUSREQ=0100 held, HREADY=1 → HGRANT=0100 after 1 edge, HMASTER=2 one edge later. Dropping HBUSREQ → HGRANT=0001 next edge.
- HBUSREQ=1111 held, SINGLE NONSEQ transfers, HREADY=1:
  - HGRANT sequence 0010, 0100, 1000, 0001, 0010.
  - HMASTER trails HGRANT by one edge.
- Manager 1 issues INCR4 (NONSEQ then 3 SEQ) while manager 3 requests:
  - Grant stays 0010 until the edge accepting the 3rd beat, then becomes 1000.
  - HMASTER=3 after the 4th beat is accepted.
  - Inserting 2 HREADY=0 cycles mid-burst delays the handover by 2 cycles.
- Manager 2 with HLOCK=1 and HBUSREQ dropped, others requesting → HGRANT stays 0100 and HMASTLOCK=1. After HLOCK falls, grant moves to manager 3 at the next HREADY=1 edge.
- Abort and reset:
  - ERROR response (HRESP=1, HREADY=0) during an INCR8 on beat 2 → beat_cnt=0 and the grant moves to the pending requester at the following HREADY=1 edge.
  - HRESET asserted mid-burst → all outputs return to their reset values on that edge.
